// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator display path
package calc_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;

  localparam int unsigned MAX_DISP    = 9999;
  localparam logic [15:0] ERR_PATTERN = 16'hEEEE;
  localparam int          BCD_DIGITS  = 4;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble corrector (>=5 gets +3)
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
  end

endmodule

// File: rtl/bin2bcd_conv.sv
// rtl/bin2bcd_conv.sv - sequential binary to 4-digit packed BCD converter
module bin2bcd_conv
  import calc_pkg::*;
#(
  parameter int DATA_W = 14
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [DATA_W-1:0] Bin_in,
  output logic              Busy,
  output logic              Done,
  output logic              Ovf,
  output logic [15:0]       disp_data
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_e            state_q;
  logic [DATA_W-1:0] bin_q;
  logic [15:0]       bcd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_flag_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;
  logic [15:0]       disp_q;

  logic [15:0]       bcd_adj;
  logic [15:0]       bcd_d;
  logic [DATA_W-1:0] bin_d;
  logic              ovf_d;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .digit_i(bcd_q[4*g +: 4]),
      .digit_o(bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    bcd_d = {bcd_adj[14:0], bin_q[DATA_W-1]};
    bin_d = {bin_q[DATA_W-2:0], 1'b0};
    ovf_d = 17'(Bin_in) > 17'(MAX_DISP);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            bin_q      <= Bin_in;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= ovf_d;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + CNT_W'(1);
          // a carry out of the thousands digit only happens for values already flagged
          ovf_flag_q <= ovf_flag_q | bcd_adj[15];
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          disp_q  <= ovf_flag_q ? ERR_PATTERN : bcd_q;
          ovf_q   <= ovf_flag_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Ovf       = ovf_q;
  assign disp_data = disp_q;

endmodule
